// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the half-duplex pad controller: FSM state encoding
// and the tri-state release level of the pad buffer enable.
package pad_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_TURN   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } pad_state_e;

   localparam logic T_RELEASE = 1'b1;

   // Counter width able to index 0..max_val-1, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/pad_sync2.sv
// Two-flop synchroniser bringing the asynchronous pad input into the CLK domain.
module pad_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   // Shift chain, cleared by the synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/pad_halfduplex_ctrl.sv
// Half-duplex bit-serial engine in front of a tri-state pad: shifts a word out
// MSB first, optionally releases the line, waits a turnaround and shifts a word in.
module pad_halfduplex_ctrl
   import pad_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4,
   parameter int TURN  = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] TX_DATA,
   input  logic             TX_RD,
   input  logic             TX_VALID,
   output logic             TX_READY,
   output logic [WIDTH-1:0] RX_DATA,
   output logic             RX_VALID,
   output logic             BUSY,
   output logic             PAD_I,
   output logic             PAD_T,
   input  logic             PAD_O
);

   localparam int TMR_W   = cnt_width(DIV);
   localparam int CNT_MAX = (WIDTH > TURN) ? WIDTH : TURN;
   localparam int CNT_W   = cnt_width(CNT_MAX);

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DIV - 1);
   localparam logic [TMR_W-1:0] TMR_MID   = TMR_W'(DIV / 2);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);

   // The mid-bit sample point must leave room for the synchroniser latency.
   if (DIV < 2) begin : g_div_check
      $error("pad_halfduplex_ctrl: DIV must be >= 2");
   end
   if (TURN < 1) begin : g_turn_check
      $error("pad_halfduplex_ctrl: TURN must be >= 1");
   end
   if (WIDTH < 2) begin : g_width_check
      $error("pad_halfduplex_ctrl: WIDTH must be >= 2");
   end

   pad_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic             rd_q, rd_d;
   logic             pad_i_q, pad_i_d;
   logic             pad_t_q, pad_t_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;

   logic             pad_sync_s;
   logic             accept_s;
   logic             period_end_s;

   pad_sync2 u_sync (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .d_i    (PAD_O),
      .q_o    (pad_sync_s)
   );

   assign accept_s     = TX_VALID && ready_q;
   assign period_end_s = (tmr_q == TMR_LAST);

   // State and datapath registers; reset aborts any transaction on the same edge.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         cnt_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rd_q       <= 1'b0;
         pad_i_q    <= 1'b0;
         pad_t_q    <= T_RELEASE;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rd_q       <= rd_d;
         pad_i_q    <= pad_i_d;
         pad_t_q    <= pad_t_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   // Next-state logic: each phase ends on the last timer tick of its last period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (period_end_s && (cnt_q == BIT_LAST)) begin
               state_d = rd_q ? ST_TURN : ST_DONE;
            end else begin
               state_d = ST_DRIVE;
            end
         end
         ST_TURN: begin
            if (period_end_s && (cnt_q == TURN_LAST)) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_TURN;
            end
         end
         ST_SAMPLE: begin
            if (period_end_s && (cnt_q == BIT_LAST)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SAMPLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bit timer, period counter and both shift registers.
   always_comb begin
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      tx_sh_d = tx_sh_q;
      rx_sh_d = rx_sh_q;
      rd_d    = rd_q;
      if (accept_s) begin
         tmr_d   = '0;
         cnt_d   = '0;
         tx_sh_d = TX_DATA;
         rd_d    = TX_RD;
      end else if ((state_q == ST_DRIVE) || (state_q == ST_TURN) || (state_q == ST_SAMPLE)) begin
         if (period_end_s) begin
            tmr_d = '0;
            cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
         end else begin
            tmr_d = tmr_q + TMR_W'(1);
            cnt_d = cnt_q;
         end
         if ((state_q == ST_DRIVE) && period_end_s) begin
            tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
         end else begin
            tx_sh_d = tx_sh_q;
         end
         if ((state_q == ST_SAMPLE) && (tmr_q == TMR_MID)) begin
            rx_sh_d = {rx_sh_q[WIDTH-2:0], pad_sync_s};
         end else begin
            rx_sh_d = rx_sh_q;
         end
      end else begin
         tmr_d = '0;
         cnt_d = '0;
      end
   end

   // Outputs are computed from the next state so they are registered yet aligned with it.
   always_comb begin
      pad_t_d    = (state_d == ST_DRIVE) ? ~T_RELEASE : T_RELEASE;
      pad_i_d    = (state_d == ST_DRIVE) ? tx_sh_d[WIDTH-1] : 1'b0;
      ready_d    = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
      rx_valid_d = (state_d == ST_DONE) && rd_q;
      if (rx_valid_d) begin
         // rx_sh_d, since with DIV=2 the last sample lands on the exit edge
         rx_data_d = rx_sh_d;
      end else begin
         rx_data_d = rx_data_q;
      end
   end

   assign TX_READY = ready_q;
   assign BUSY     = busy_q;
   assign RX_VALID = rx_valid_q;
   assign RX_DATA  = rx_data_q;
   assign PAD_I    = pad_i_q;
   assign PAD_T    = pad_t_q;

endmodule

// File: tb/tb_pad_halfduplex_ctrl.sv
// Randomised bench for pad_halfduplex_ctrl: two instances (8/4/2 and 16/2/1) on a
// pulled-up half-duplex line with a behavioural remote device answering reads.
module tb_pad_halfduplex_ctrl;
   import pad_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   sel    = 0;

   logic        dev_oe  = 1'b0;
   logic        dev_bit = 1'b0;
   logic [15:0] model_rx [2];

   logic [7:0]  a_tx_data, a_rx_data;
   logic        a_tx_rd, a_tx_valid, a_tx_ready, a_rx_valid, a_busy, a_pad_i, a_pad_t, a_line;
   logic [15:0] b_tx_data, b_rx_data;
   logic        b_tx_rd, b_tx_valid, b_tx_ready, b_rx_valid, b_busy, b_pad_i, b_pad_t, b_line;

   // Resolved line: controller when enabled, else the device, else the pull-up.
   assign a_line = !a_pad_t ? a_pad_i : ((sel == 0 && dev_oe) ? dev_bit : 1'b1);
   assign b_line = !b_pad_t ? b_pad_i : ((sel == 1 && dev_oe) ? dev_bit : 1'b1);

   pad_halfduplex_ctrl #(.WIDTH(8), .DIV(4), .TURN(2)) dut_a (
      .CLK(clk), .RST_N(rst_n), .TX_DATA(a_tx_data), .TX_RD(a_tx_rd), .TX_VALID(a_tx_valid),
      .TX_READY(a_tx_ready), .RX_DATA(a_rx_data), .RX_VALID(a_rx_valid), .BUSY(a_busy),
      .PAD_I(a_pad_i), .PAD_T(a_pad_t), .PAD_O(a_line));

   pad_halfduplex_ctrl #(.WIDTH(16), .DIV(2), .TURN(1)) dut_b (
      .CLK(clk), .RST_N(rst_n), .TX_DATA(b_tx_data), .TX_RD(b_tx_rd), .TX_VALID(b_tx_valid),
      .TX_READY(b_tx_ready), .RX_DATA(b_rx_data), .RX_VALID(b_rx_valid), .BUSY(b_busy),
      .PAD_I(b_pad_i), .PAD_T(b_pad_t), .PAD_O(b_line));

   logic        o_pad_t, o_pad_i, o_ready, o_rxv, o_busy, o_excl_bad;
   logic [15:0] o_rx_data;
   always_comb begin
      if (sel == 1) begin
         o_pad_t = b_pad_t; o_pad_i = b_pad_i; o_ready = b_tx_ready; o_rxv = b_rx_valid;
         o_busy = b_busy; o_rx_data = b_rx_data;
         o_excl_bad = (dut_b.state_q == ST_SAMPLE) && (b_pad_t == 1'b0);
      end else begin
         o_pad_t = a_pad_t; o_pad_i = a_pad_i; o_ready = a_tx_ready; o_rxv = a_rx_valid;
         o_busy = a_busy; o_rx_data = {8'h00, a_rx_data};
         o_excl_bad = (dut_a.state_q == ST_SAMPLE) && (a_pad_t == 1'b0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic [15:0] data, input logic rd);
      if (sel == 1) begin
         b_tx_valid = v; b_tx_data = data; b_tx_rd = rd;
      end else begin
         a_tx_valid = v; a_tx_data = data[7:0]; a_tx_rd = rd;
      end
   endtask

   task automatic wait_ready(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_ready === 1'b1) break;
      end
      chk("ready_wait", 32'(o_ready), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_pad_t"}, 32'(o_pad_t), 32'd1);
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_rx_valid"}, 32'(o_rxv), 32'd0);
      chk({tag, "_rx_data"}, 32'(o_rx_data), 32'd0);
   endtask

   // One transaction from the bench's point of view. Index n counts edges since accept.
   // The device launches each reply bit one cycle ahead of its nominal bit period.
   task automatic run_txn(input int w, input int d, input int t, input logic [15:0] data_in,
                          input logic rd, input logic [15:0] answer_in, input int abort_at);
      logic [15:0] mask, data, answer, got_word, got_rx;
      logic        held_ok, idle_ok, contend_ok, excl_ok;
      int          drv_cnt, last_drv, drive_end, first_ready, rxv_cnt, rxv_idx, limit, j;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      data = data_in & mask;
      answer = answer_in & mask;
      got_word = 16'h0000; got_rx = 16'h0000;
      held_ok = 1'b1; idle_ok = 1'b1; contend_ok = 1'b1; excl_ok = 1'b1;
      drv_cnt = 0; last_drv = -1; drive_end = -1; first_ready = -1; rxv_cnt = 0; rxv_idx = -1;
      limit = (2 * w + t) * d + 8;
      wait_ready(200);
      set_req(1'b1, data, rd);
      @(posedge clk);
      #1 set_req(1'b0, 16'h0000, 1'b0);
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (n < w * d) begin
            if (o_pad_t !== 1'b0) held_ok = 1'b0;
            if (n % d == 0) got_word[w - 1 - n / d] = o_pad_i;
            else if (o_pad_i !== got_word[w - 1 - n / d]) held_ok = 1'b0;
         end
         if (o_pad_t === 1'b0) begin
            drv_cnt++; last_drv = n;
         end else if (drive_end < 0 && last_drv >= 0) begin
            drive_end = n;
         end
         if (o_pad_t === 1'b1 && o_pad_i !== 1'b0) idle_ok = 1'b0;
         if (o_pad_t === 1'b0 && dev_oe) contend_ok = 1'b0;
         if (o_excl_bad) excl_ok = 1'b0;
         if (o_rxv === 1'b1) begin
            rxv_cnt++; rxv_idx = n; got_rx = o_rx_data;
         end
         dev_oe = 1'b0;
         if (rd && drive_end >= 0) begin
            j = n - (drive_end + t * d - 1);
            if (j >= 0 && j < w * d) begin
               dev_oe = 1'b1; dev_bit = answer[w - 1 - j / d];
            end
         end
         if (n == abort_at) begin
            rst_n = 1'b0;
            break;
         end
         if (o_ready === 1'b1 && first_ready < 0) begin
            first_ready = n;
            break;
         end
      end
      dev_oe = 1'b0;
      if (abort_at >= 0) begin
         @(negedge clk);
         check_reset_state("abort");
         chk("abort_no_rx_valid", 32'(rxv_cnt), 32'd0);
         model_rx[0] = 16'h0000; model_rx[1] = 16'h0000;
         rst_n = 1'b1;
         rxv_cnt = 0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_rxv === 1'b1) rxv_cnt++;
         end
         chk("abort_quiet", 32'(rxv_cnt), 32'd0);
      end else begin
         chk("drive_word", 32'(got_word), 32'(data));
         chk("drive_hold", 32'(held_ok), 32'd1);
         chk("drive_cycles", 32'(drv_cnt), 32'(w * d));
         chk("drive_last_idx", 32'(last_drv), 32'(w * d - 1));
         chk("line_idle_low", 32'(idle_ok), 32'd1);
         chk("no_contention", 32'(contend_ok), 32'd1);
         chk("drive_not_sample", 32'(excl_ok), 32'd1);
         chk("ready_latency", 32'(first_ready), rd ? 32'((2 * w + t) * d + 1) : 32'(w * d + 1));
         chk("rx_valid_count", 32'(rxv_cnt), rd ? 32'd1 : 32'd0);
         if (rd) begin
            chk("rx_valid_index", 32'(rxv_idx), 32'((2 * w + t) * d));
            chk("rx_data", 32'(got_rx), 32'(answer));
            model_rx[sel] = answer;
         end
         chk("rx_hold", 32'(o_rx_data), 32'(model_rx[sel]));
      end
   endtask

   initial begin
      int accepts, second_idx;
      logic [15:0] rd_word, ans_word;
      logic        rd_bit;
      rst_n = 1'b0;
      a_tx_valid = 1'b0; a_tx_data = 8'h00; a_tx_rd = 1'b0;
      b_tx_valid = 1'b0; b_tx_data = 16'h0000; b_tx_rd = 1'b0;
      model_rx[0] = 16'h0000; model_rx[1] = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel = 0;
      check_reset_state("reset_a");
      sel = 1;
      check_reset_state("reset_b");
      sel = 0;
      rst_n = 1'b1;

      run_txn(8, 4, 2, 16'h00A5, 1'b0, 16'h0000, -1);
      run_txn(8, 4, 2, 16'h003C, 1'b1, 16'h00C3, -1);

      // TX_VALID held high across a whole write: only two accepts in the window.
      wait_ready(100);
      set_req(1'b1, 16'h005A, 1'b0);
      accepts = 0; second_idx = -1;
      for (int n = 0; n < 61; n++) begin
         if (o_ready === 1'b1) begin
            accepts++;
            if (accepts == 2) second_idx = n;
         end
         @(negedge clk);
      end
      set_req(1'b0, 16'h0000, 1'b0);
      chk("b2b_accepts", 32'(accepts), 32'd2);
      chk("b2b_second_accept", 32'(second_idx), 32'd34);
      wait_ready(100);

      run_txn(8, 4, 2, 16'h0081, 1'b1, 16'h0066, (8 + 2) * 4 + 3 * 4 + 1);
      run_txn(8, 4, 2, 16'h0042, 1'b1, 16'h00E7, -1);

      for (int k = 0; k < 8; k++) begin
         rd_word = 16'($urandom_range(0, 255));
         ans_word = 16'($urandom_range(0, 255));
         rd_bit = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_txn(8, 4, 2, rd_word, rd_bit, ans_word, -1);
      end

      sel = 1;
      run_txn(16, 2, 1, 16'h1234, 1'b1, 16'hBEEF, -1);
      for (int k = 0; k < 4; k++) begin
         rd_word = 16'($urandom_range(0, 65535));
         ans_word = 16'($urandom_range(0, 65535));
         rd_bit = 1'($urandom_range(0, 1));
         run_txn(16, 2, 1, rd_word, rd_bit, ans_word, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
